aes_key_expand: RTL

Parametrised iterative AES key-expansion engine for the pipelined encryption datapath; supports AES-128 and AES-256 from one source. On a single-cycle `start` pulse it captures the cipher key and generates the full round-key schedule at one 32-bit word per clock into an internal register file. Round keys are then served through a registered read port to the round stages. It replaces the fixed 128-bit, `fsm_en`-triggered key setup with a handshaked, key-length-generic block that supports re-keying.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_key_expand_if.sv | 32 +++
 rtl/aes_key_expand_subword.sv | 15 +
 rtl/aes_key_expand.sv | 132 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the key-expansion engine and the round
// pipeline: the forward S-box, GF(2^8) xtime, the key-expansion state enum and
// the NK/NR derivation helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic {
        KE_IDLE,
        KE_EXPAND
    } ke_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8), reducing modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// -----------------------------------------------------------------------------
// aes_key_expand_if
// Request/status/read bundle of the key-expansion engine.
//   start      : one-cycle expansion request (master -> slave)
//   key_in     : cipher key, w[0] in the top 32 bits (master -> slave)
//   rd_round   : round-key index to read (master -> slave)
//   busy       : expansion in progress (slave -> master)
//   done       : one-cycle completion pulse (slave -> master)
//   keys_valid : schedule complete and consistent (slave -> master)
//   rd_key     : registered round key for rd_round (slave -> master)
// -----------------------------------------------------------------------------
interface aes_key_expand_if #(
    parameter int KEY_BITS = 128
);
    logic                start;
    logic [KEY_BITS-1:0] key_in;
    logic [3:0]          rd_round;
    logic                busy;
    logic                done;
    logic                keys_valid;
    logic [127:0]        rd_key;

    modport master (
        output start, key_in, rd_round,
        input  busy, done, keys_valid, rd_key
    );

    modport slave (
        input  start, key_in, rd_round,
        output busy, done, keys_valid, rd_key
    );
endinterface

// File: rtl/aes_key_expand_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// Combinational AES SubWord: applies the S-box to each byte of a 32-bit word.
//   word_i : input word
//   word_o : substituted word
// -----------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};
endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Iterative AES-128/AES-256 key expansion. A start pulse in IDLE captures the
// key; one schedule word is generated per clock into a register array, and
// round keys are then served through a registered read port.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : aes_key_expand_if.slave (start/key_in/rd_round in,
//         busy/done/keys_valid/rd_key out)
// -----------------------------------------------------------------------------
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic               clk,
    input  logic               rst,
    aes_key_expand_if.slave    bus
);
    localparam int NK    = nk_of(KEY_BITS);
    localparam int NR    = nr_of(KEY_BITS);
    localparam int TOTAL = 4 * (NR + 1);

    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [5:0] MOD_MASK = 6'(NK - 1);
    localparam logic [5:0] LAST_IDX = 6'(TOTAL - 1);
    localparam logic [3:0] NR_W     = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_key_expand: KEY_BITS must be 128 or 256");
        end
    endgenerate

    ke_state_e    state_q;
    logic [5:0]   idx_q;
    logic [7:0]   rcon_q;
    logic         busy_q;
    logic         done_q;
    logic         keys_valid_q;
    logic [127:0] rd_key_q;
    logic [31:0]  w_q [TOTAL];

    logic [5:0]   prev_idx, back_idx, rd_base;
    logic [31:0]  prev_word, back_word, sub_in, sub_out, temp, word_d;
    logic         rot_step, sub_step;
    logic [127:0] rd_key_d;

    // One S-box path serves both the RotWord step and the AES-256 mid-step.
    aes_subword u_subword (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        // NOTE: every always_comb output gets a value before any branch, so no
        // path can leave it unassigned and infer a latch.
        temp      = '0;
        rd_key_d  = '0;
        prev_idx  = idx_q - 6'd1;
        back_idx  = idx_q - NK_W;
        prev_word = w_q[prev_idx];
        back_word = w_q[back_idx];
        rot_step  = (idx_q & MOD_MASK) == 6'd0;
        sub_step  = (NK == 8) && (idx_q[2:0] == 3'd4);
        sub_in    = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;

        if (rot_step)      temp = sub_out ^ {rcon_q, 24'h0};
        else if (sub_step) temp = sub_out;
        else               temp = prev_word;
        word_d = back_word ^ temp;

        rd_base = {bus.rd_round, 2'b00};
        if (bus.rd_round <= NR_W) begin
            rd_key_d = {w_q[rd_base],         w_q[rd_base + 6'd1],
                        w_q[rd_base + 6'd2],  w_q[rd_base + 6'd3]};
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= KE_IDLE;
            idx_q        <= '0;
            rcon_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q     <= '0;
            // NOTE: the word array is flops, not RAM, so it is cleared on reset
            // and a reset mid-expansion leaves no partial schedule behind.
            for (int i = 0; i < TOTAL; i++) w_q[i] <= '0;
        end else begin
            done_q   <= 1'b0;
            rd_key_q <= rd_key_d;
            case (state_q)
                KE_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NK; i++)
                            w_q[i] <= bus.key_in[KEY_BITS-1-32*i -: 32];
                        idx_q        <= NK_W;
                        rcon_q       <= 8'h01;
                        keys_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= KE_EXPAND;
                    end
                end
                KE_EXPAND: begin
                    w_q[idx_q] <= word_d;
                    if (rot_step) rcon_q <= xtime(rcon_q);
                    if (idx_q == LAST_IDX) begin
                        // idx parks on the last word rather than wrapping.
                        state_q      <= KE_IDLE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        keys_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                default: state_q <= KE_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.rd_key     = rd_key_q;

endmodule
